// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 2-flop synchronizer, start/data/stop FSM, one-entry holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority decisions (adds one cycle of decision latency).
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_sig,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int unsigned PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int unsigned CW = $clog2(PULSE_WIDTH) + 1;
    localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] BIT_RELOAD  = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF_PULSE_WIDTH - 1);
    localparam logic [IW-1:0] LAST_IDX    = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic                  sync1, rxs, rxs_d;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [DATA_WIDTH-1:0] word, word_nxt;
    logic                  sample_now, decide, bit_val;
    logic                  deliver, ferr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b0;
        end else begin
            sync1 <= rx_sig;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    assign sample_now = (state == START || state == DATA || state == STOP) && (cnt == '0);

`ifdef UART_RX_MAJORITY_EN
    logic rxs_dd, pend;

    // The counter keeps running through the deferred decision cycle, so bit spacing is unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxs_dd <= 1'b0;
            pend   <= 1'b0;
        end else begin
            rxs_dd <= rxs_d;
            pend   <= sample_now;
        end
    end

    assign decide  = pend;
    assign bit_val = (rxs_dd & rxs_d) | (rxs_dd & rxs) | (rxs_d & rxs);
`else
    assign decide  = sample_now;
    assign bit_val = rxs;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            word  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            word  <= word_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        word_nxt  = word;
        deliver   = 1'b0;
        ferr      = 1'b0;

        if (state == START || state == DATA || state == STOP)
            cnt_nxt = sample_now ? BIT_RELOAD : cnt - CW'(1);

        case (state)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    cnt_nxt   = HALF_RELOAD;
                    state_nxt = START;
                end
            end
            START: begin
                if (decide) begin
                    if (bit_val) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    word_nxt[idx] = bit_val;
                    if (idx == LAST_IDX)
                        state_nxt = STOP;
                    else
                        idx_nxt = idx + IW'(1);
                end
            end
            STOP: begin
                if (decide) begin
                    deliver   = bit_val;
                    ferr      = !bit_val;
                    state_nxt = bit_val ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= 1'b0;
            if (deliver) begin
                // A consumer taking the old word this cycle frees the slot for the new one.
                if (!valid || ready) begin
                    data  <= word;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (PULSE_WIDTH=10, HALF_PULSE_WIDTH=5).
module tb_uart_rx;

    localparam int PW = 10;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx_sig = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE (100_000),
        .CLK_FREQ  (1_000_000)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_sig   (rx_sig),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    int n_cmp = 0;
    int n_fail = 0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         n_valid = 0, n_acc = 0, n_fe = 0, n_ov = 0, rise_cyc = -1;
    logic [7:0] acc_data = '0;
    logic       valid_q = 1'b0;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (valid && !valid_q) rise_cyc = cyc;
        if (valid && ready) begin
            n_acc++;
            acc_data = data;
        end
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        valid_q = valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Drives {stop, d, start} one bit per PW cycles; line cycle 'glitch' is inverted.
    task automatic send(input logic [7:0] d, input logic stop, input int ncyc,
                        input int glitch, output int c0);
        logic [9:0] f;
        logic       v;
        f = {stop, d, 1'b0};
        tick(1);
        c0 = cyc;
        for (int k = 0; k < ncyc; k++) begin
            v = f[k / PW];
            if (k == glitch) v = ~v;
            rx_sig = v;
            tick(1);
        end
    endtask

    int c0, c1, base_v;

    initial begin
        tick(3);
        check("rst_valid", 32'(valid), 0);
        check("rst_data", 32'(data), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        rstn = 1'b1;
        tick(5);

        // Single frame, ready held high
        ready = 1'b1;
        send(8'hA5, 1'b1, 100, -1, c0);
        rx_sig = 1'b1;
        tick(5);
        check("a5_data", 32'(acc_data), 'hA5);
        check("a5_rise_cycle", rise_cyc, c0 + 98 + LAT);
        check("a5_valid_cycles", n_valid, 1);
        check("a5_accepts", n_acc, 1);
        check("a5_frame_err", n_fe, 0);
        check("a5_overrun", n_ov, 0);
        check("a5_valid_low", 32'(valid), 0);

        // Back-to-back frames with the holding register full
        ready = 1'b0;
        send(8'h3C, 1'b1, 100, -1, c0);
        send(8'hC3, 1'b1, 100, -1, c1);
        rx_sig = 1'b1;
        tick(5);
        check("ovr_pulses", n_ov, 1);
        check("ovr_valid", 32'(valid), 1);
        check("ovr_data_held", 32'(data), 'h3C);
        check("ovr_frame_err", n_fe, 0);
        ready = 1'b1;
        tick(1);
        check("ovr_drain_valid", 32'(valid), 0);
        check("ovr_drain_data", 32'(data), 'h3C);

        // Stop bit low, then recovery
        base_v = n_valid;
        send(8'h55, 1'b0, 100, -1, c0);
        rx_sig = 1'b1;
        tick(20);
        check("ferr_pulses", n_fe, 1);
        check("ferr_no_valid", n_valid, base_v);
        send(8'h0F, 1'b1, 100, -1, c0);
        rx_sig = 1'b1;
        tick(5);
        check("ferr_next_data", 32'(acc_data), 'h0F);
        check("ferr_next_accepts", n_acc, 2);

        // Short low glitch on idle line
        base_v = n_valid;
        rx_sig = 1'b0;
        tick(3);
        rx_sig = 1'b1;
        tick(30);
        check("glitch_no_valid", n_valid, base_v);
        check("glitch_no_ferr", n_fe, 1);
        send(8'hFF, 1'b1, 100, -1, c0);
        rx_sig = 1'b1;
        tick(5);
        check("glitch_next_data", 32'(acc_data), 'hFF);
        check("glitch_next_accepts", n_acc, 3);

        // Reset during data bit 4
        base_v = n_valid;
        send(8'h5A, 1'b1, 55, -1, c0);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_data", 32'(data), 0);
        check("mid_rst_frame_err", 32'(frame_err), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        rx_sig = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(3);
        rx_sig = 1'b1;
        tick(30);
        check("post_rst_no_valid", n_valid, base_v);
        check("post_rst_no_ferr", n_fe, 1);
        check("post_rst_no_ovr", n_ov, 1);
        send(8'h81, 1'b1, 100, -1, c0);
        rx_sig = 1'b1;
        tick(5);
        check("post_rst_data", 32'(acc_data), 'h81);
        check("post_rst_accepts", n_acc, 4);
        check("post_rst_valid_cycles", n_valid, base_v + 1);

        // One-cycle high glitch at the centre of data bit 2
        send(8'h00, 1'b1, 100, 35, c0);
        rx_sig = 1'b1;
        tick(5);
        check("bit2_glitch_data", 32'(acc_data), (LAT == 1) ? 'h00 : 'h04);
        check("bit2_glitch_accepts", n_acc, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
